// File: rtl/avalon_timer_master.sv
// Avalon-MM master for the 32-bit timer slave: turns one-cycle local commands
// (read/start/stop/clear) into single bus transfers with one response each.
module avalon_timer_master #(
  parameter logic [7:0] TIMER_ADDR   = 8'h00,
  parameter int         READ_LATENCY = 1,
  parameter int         TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  output logic        cmd_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [7:0]  avm_address,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  typedef enum logic [1:0] {IDLE, XFER, LAT, RSP} state_t;

  localparam logic [2:0]  LAT_INIT  = 3'(READ_LATENCY);
  localparam logic [15:0] STALL_MAX = 16'(TIMEOUT);

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] stall_q, stall_d;
  logic [2:0]  lat_q, lat_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic [7:0]  addr_q, addr_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic        read_q, read_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= 2'd0;
      stall_q     <= 16'd0;
      lat_q       <= 3'd0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_err_q   <= 1'b0;
      addr_q      <= TIMER_ADDR;
      write_q     <= 1'b0;
      wdata_q     <= 32'd0;
      read_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      stall_q     <= stall_d;
      lat_q       <= lat_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      read_q      <= read_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    stall_d     = stall_q;
    lat_d       = lat_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    addr_d      = TIMER_ADDR;
    write_d     = write_q;
    wdata_d     = wdata_q;
    read_d      = read_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          stall_d = 16'd0;
          state_d = XFER;
          if (cmd_op != 2'd0) begin
            write_d = 1'b1;
            wdata_d = {30'd0, cmd_op};
          end else begin
            read_d = 1'b1;
          end
        end
      end
      XFER: begin
        if (!avm_waitrequest) begin
          write_d = 1'b0;
          read_d  = 1'b0;
          if (op_q != 2'd0) begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 32'd0;
            rsp_err_d   = 1'b0;
          end else begin
            state_d = LAT;
            lat_d   = LAT_INIT;
          end
        end else if (stall_q + 16'd1 == STALL_MAX) begin
          // This stalled edge is the TIMEOUT-th one: abandon the transfer.
          stall_d     = STALL_MAX;
          write_d     = 1'b0;
          read_d      = 1'b0;
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = 32'd0;
          rsp_err_d   = 1'b1;
        end else begin
          stall_d = stall_q + 16'd1;
        end
      end
      LAT: begin
        if (lat_q == 3'd1) begin
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = avm_readdata;
          rsp_err_d   = 1'b0;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      RSP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake outputs are registered, so they follow the state being entered.
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  assign cmd_ready     = cmd_ready_q;
  assign busy          = busy_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign avm_address   = addr_q;
  assign avm_write     = write_q;
  assign avm_writedata = wdata_q;
  assign avm_read      = read_q;

endmodule

// File: tb/tb_avalon_timer_master.sv
// Directed bench for avalon_timer_master with a small timer-slave model
// (start/stop/clear, one-cycle read latency, bench-controlled waitrequest).
module tb_avalon_timer_master;

  localparam logic [7:0] ADDR = 8'h2C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic [7:0]  avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // timer slave model
  logic [31:0] tmr_cnt = 32'd0;
  logic        tmr_run = 1'b0;
  logic [31:0] tmr_rd  = 32'hDEAD_BEEF;
  logic        preload_en = 1'b0;
  logic [31:0] preload_val = 32'd0;
  logic        overlap_seen = 1'b0;

  avalon_timer_master #(
    .TIMER_ADDR  (ADDR),
    .READ_LATENCY(1),
    .TIMEOUT     (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_op         (cmd_op),
    .cmd_ready      (cmd_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .busy           (busy),
    .avm_address    (avm_address),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_read       (avm_read),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload_en) tmr_cnt <= preload_val;
    else if (avm_write && !avm_waitrequest) begin
      case (avm_writedata)
        32'd1:   tmr_run <= 1'b1;
        32'd2:   tmr_run <= 1'b0;
        32'd3:   tmr_cnt <= 32'd0;
        default: ;
      endcase
    end else if (tmr_run) tmr_cnt <= tmr_cnt + 32'd1;
    // Read data is only valid in the single cycle after the completing edge.
    tmr_rd <= (avm_read && !avm_waitrequest) ? tmr_cnt : 32'hDEAD_BEEF;
  end
  assign avm_readdata = tmr_rd;

  always @(negedge clk) if (avm_write && avm_read) overlap_seen = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge after rsp_valid
  // has dropped. lat = clock edges from the accept edge to rsp_valid high.
  task automatic run_cmd(input logic [1:0] op, output int lat,
                         output logic [31:0] d, output logic e);
    logic got;
    got = 1'b0; lat = 0; d = 32'd0; e = 1'b0;
    cmd_valid = 1'b1; cmd_op = op;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      if (rsp_valid) begin
        got = 1'b1; d = rsp_data; e = rsp_err;
      end else begin
        lat++;
        @(negedge clk);
      end
    end
    check_val("rsp_seen", 32'(got), 32'd1);
    @(negedge clk);
    check_val("ready_after_rsp", 32'(cmd_ready), 32'd1);
  endtask

  int          lat;
  logic [31:0] d;
  logic        e;
  int          cyc_hi, rsp_cnt, stable, err_seen;

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_write", 32'(avm_write), 32'd0);
    check_val("rst_read", 32'(avm_read), 32'd0);
    check_val("rst_ready", 32'(cmd_ready), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_addr", 32'(avm_address), 32'(ADDR));
    check_val("rst_wdata", avm_writedata, 32'd0);
    reset = 1'b0;

    // START with no stall, checked cycle by cycle
    cmd_valid = 1'b1; cmd_op = 2'd1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_val("start_write", 32'(avm_write), 32'd1);
    check_val("start_wdata", avm_writedata, 32'd1);
    check_val("start_addr", 32'(avm_address), 32'(ADDR));
    check_val("start_no_read", 32'(avm_read), 32'd0);
    check_val("start_busy", 32'(busy), 32'd1);
    check_val("start_not_ready", 32'(cmd_ready), 32'd0);
    check_val("start_no_rsp_yet", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check_val("start_write_drop", 32'(avm_write), 32'd0);
    check_val("start_rsp_valid", 32'(rsp_valid), 32'd1);
    check_val("start_rsp_data", rsp_data, 32'd0);
    check_val("start_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    check_val("start_rsp_one_cycle", 32'(rsp_valid), 32'd0);
    check_val("start_ready_back", 32'(cmd_ready), 32'd1);

    // Timer ran from the edge after start completion to the stop completion edge.
    repeat (100) @(negedge clk);
    run_cmd(2'd2, lat, d, e);
    check_val("stop_lat", 32'(lat), 32'd1);
    check_val("stop_err", 32'(e), 32'd0);
    run_cmd(2'd0, lat, d, e);
    check_val("read_lat", 32'(lat), 32'd2);
    check_val("read_value", d, 32'd102);
    check_val("read_err", 32'(e), 32'd0);

    // CLEAR a stopped timer holding 0x40
    preload_en = 1'b1; preload_val = 32'h40;
    @(negedge clk);
    preload_en = 1'b0;
    run_cmd(2'd0, lat, d, e);
    check_val("read_preload", d, 32'h40);
    run_cmd(2'd3, lat, d, e);
    check_val("clear_err", 32'(e), 32'd0);
    run_cmd(2'd0, lat, d, e);
    check_val("read_after_clear", d, 32'd0);

    // Write stalled for 5 edges
    avm_waitrequest = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'd2;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc_hi = 0; rsp_cnt = 0; stable = 1; err_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (avm_write) begin
        cyc_hi++;
        if (avm_writedata != 32'd2 || avm_address != ADDR) stable = 0;
      end
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_err) err_seen = 1;
      end
      if (i == 5) avm_waitrequest = 1'b0;
      @(negedge clk);
    end
    check_val("stall_write_cycles", 32'(cyc_hi), 32'd6);
    check_val("stall_write_stable", 32'(stable), 32'd1);
    check_val("stall_rsp_count", 32'(rsp_cnt), 32'd1);
    check_val("stall_rsp_err", 32'(err_seen), 32'd0);

    // Waitrequest stuck high: timeout after 8 stalled edges
    avm_waitrequest = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'd0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc_hi = 0; rsp_cnt = 0; err_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (avm_read) cyc_hi++;
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_err) err_seen = 1;
      end
      @(negedge clk);
    end
    check_val("timeout_read_cycles", 32'(cyc_hi), 32'd8);
    check_val("timeout_rsp_count", 32'(rsp_cnt), 32'd1);
    check_val("timeout_rsp_err", 32'(err_seen), 32'd1);
    check_val("timeout_ready", 32'(cmd_ready), 32'd1);

    // Reset in the middle of a stalled READ
    cmd_valid = 1'b1; cmd_op = 2'd0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_val("midrst_read_before", 32'(avm_read), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_val("midrst_read_async_drop", 32'(avm_read), 32'd0);
    check_val("midrst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    rsp_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) rsp_cnt++;
      @(negedge clk);
    end
    check_val("midrst_no_rsp", 32'(rsp_cnt), 32'd0);
    run_cmd(2'd1, lat, d, e);
    check_val("post_rst_lat", 32'(lat), 32'd1);
    check_val("post_rst_err", 32'(e), 32'd0);
    check_val("post_rst_data", d, 32'd0);

    check_val("no_rd_wr_overlap", 32'(overlap_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
